cmd_auth: RTL and testbench

CMD_AUTH -- requirements
Module: cmd_auth

---
 rtl/cmd_auth.sv | 177 +++++++++++++++++
 tb/tb_cmd_auth.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_auth.sv
// cmd_auth: 8N1 UART receiver feeding a 'G'/'S' authorization FSM that drives pwr_up.
// Define CMD_AUTH_FRAME_CHECK_EN to reject frames whose stop bit samples low.
module cmd_auth #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_START  = 2'd1;
  localparam logic [1:0] RX_DATA   = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [1:0] AUTH_OFF  = 2'd0;
  localparam logic [1:0] AUTH_PWR1 = 2'd1;
  localparam logic [1:0] AUTH_PWR2 = 2'd2;

  // Counter counts reload..0 inclusive, so a reload of BAUD_DIV-1 spaces samples BAUD_DIV clocks apart.
  localparam logic [11:0] HALF_BIT = 12'(BAUD_DIV / 2);
  localparam logic [11:0] FULL_BIT = 12'(BAUD_DIV - 1);

  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [1:0]  settle;
  logic        fall;
  logic [1:0]  rx_st;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [1:0]  auth_st;
  logic [1:0]  auth_nxt;
`ifdef CMD_AUTH_FRAME_CHECK_EN
  logic        stop_wait;
`endif

  // settle keeps the reset value of the synchronizer from looking like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b0;
      settle  <= 2'b00;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      settle  <= {settle[0], 1'b1};
      rx_prev <= rx_sync & settle[1];
    end
  end

  assign fall = settle[1] & rx_prev & ~rx_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_st     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b0;
`ifdef CMD_AUTH_FRAME_CHECK_EN
      frm_err   <= 1'b0;
      stop_wait <= 1'b0;
`endif
    end else begin
      rx_rdy  <= 1'b0;
`ifdef CMD_AUTH_FRAME_CHECK_EN
      frm_err <= 1'b0;
`endif
      case (rx_st)
        RX_IDLE: begin
          if (fall) begin
            rx_st    <= RX_START;
            baud_cnt <= HALF_BIT;
          end
        end
        RX_START: begin
          if (baud_cnt == '0) begin
            if (!rx_sync) begin
              rx_st    <= RX_DATA;
              baud_cnt <= FULL_BIT;
              bit_cnt  <= '0;
            end else begin
              rx_st <= RX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == '0) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            baud_cnt  <= FULL_BIT;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_st <= RX_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        RX_STOP: begin
`ifdef CMD_AUTH_FRAME_CHECK_EN
          // A low stop bit may be a break; hold here until the line idles high.
          if (stop_wait) begin
            if (rx_sync) begin
              stop_wait <= 1'b0;
              rx_st     <= RX_IDLE;
            end
          end else if (baud_cnt == '0) begin
            if (rx_sync) begin
              rx_data <= shift_reg;
              rx_rdy  <= 1'b1;
              rx_st   <= RX_IDLE;
            end else begin
              frm_err   <= 1'b1;
              stop_wait <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
`else
          if (baud_cnt == '0) begin
            rx_data <= shift_reg;
            rx_rdy  <= 1'b1;
            rx_st   <= RX_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
`endif
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

`ifndef CMD_AUTH_FRAME_CHECK_EN
  assign frm_err = 1'b0;
`endif

  // rider_off in PWR2 wins over a simultaneous 'G'.
  always_comb begin
    auth_nxt = auth_st;
    case (auth_st)
      AUTH_OFF: begin
        if (rx_rdy && rx_data == 8'h47) auth_nxt = AUTH_PWR1;
      end
      AUTH_PWR1: begin
        if (rx_rdy && rx_data == 8'h53) auth_nxt = rider_off ? AUTH_OFF : AUTH_PWR2;
      end
      AUTH_PWR2: begin
        if (rider_off)                       auth_nxt = AUTH_OFF;
        else if (rx_rdy && rx_data == 8'h47) auth_nxt = AUTH_PWR1;
      end
      default: auth_nxt = AUTH_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auth_st <= AUTH_OFF;
      pwr_up  <= 1'b0;
    end else begin
      auth_st <= auth_nxt;
      pwr_up  <= (auth_st != AUTH_OFF);
    end
  end

endmodule

// File: tb/tb_cmd_auth.sv
// Directed bench for cmd_auth: instance a at BAUD_DIV=16, instance b at BAUD_DIV=2604.
module tb_cmd_auth;

  localparam int DIV_A = 16;
  localparam int DIV_B = 2604;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       rider_off_a = 1'b0;
  logic       rider_off_b = 1'b0;
  logic       pwr_up_a, pwr_up_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_rdy_a, rx_rdy_b;
  logic       frm_err_a, frm_err_b;

  int checks = 0;
  int failures = 0;
  int rdy_a = 0;
  int err_a = 0;
  int rdy_b = 0;

  cmd_auth #(.BAUD_DIV(DIV_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_a), .rider_off(rider_off_a),
    .pwr_up(pwr_up_a), .rx_data(rx_data_a), .rx_rdy(rx_rdy_a), .frm_err(frm_err_a)
  );

  cmd_auth #(.BAUD_DIV(DIV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .RX(rx_b), .rider_off(rider_off_b),
    .pwr_up(pwr_up_b), .rx_data(rx_data_b), .rx_rdy(rx_rdy_b), .frm_err(frm_err_b)
  );

  always #5 clk = ~clk;

  // Count cycles each pulse output is high; a stuck pulse inflates the count.
  always @(negedge clk) begin
    if (rx_rdy_a === 1'b1)  rdy_a++;
    if (frm_err_a === 1'b1) err_a++;
    if (rx_rdy_b === 1'b1)  rdy_b++;
  end

  task automatic send(input bit sel, input int div, input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel) rx_b = bits[i]; else rx_a = bits[i];
      repeat (div) @(posedge clk);
      #1;
    end
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL rst_pwr_up_a: got %b want 0", pwr_up_a); end
    checks++; if (rx_rdy_a !== 1'b0) begin failures++; $display("FAIL rst_rx_rdy_a: got %b want 0", rx_rdy_a); end
    checks++; if (frm_err_a !== 1'b0) begin failures++; $display("FAIL rst_frm_err_a: got %b want 0", frm_err_a); end
    checks++; if (rx_data_a !== 8'h00) begin failures++; $display("FAIL rst_rx_data_a: got %h want 00", rx_data_a); end
    checks++; if (pwr_up_b !== 1'b0) begin failures++; $display("FAIL rst_pwr_up_b: got %b want 0", pwr_up_b); end
    checks++; if (rx_data_b !== 8'h00) begin failures++; $display("FAIL rst_rx_data_b: got %h want 00", rx_data_b); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // 'G' from OFF: pwr_up must rise exactly two clocks after the rx_rdy cycle.
  task automatic test_grant();
    int base;
    int t;
    base = rdy_a;
    fork
      send(1'b0, DIV_A, 8'h47, 1'b1);
      begin
        t = 0;
        while (rx_rdy_a !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        checks++;
        if (t >= 400) begin
          failures++; $display("FAIL g_rdy_timeout: got no rx_rdy want pulse");
        end else begin
          if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL g_pwr_at_rdy: got %b want 0", pwr_up_a); end
          @(negedge clk);
          checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL g_pwr_state_cycle: got %b want 0", pwr_up_a); end
          @(negedge clk);
          checks++; if (pwr_up_a !== 1'b1) begin failures++; $display("FAIL g_pwr_rise: got %b want 1", pwr_up_a); end
        end
      end
    join
    repeat (2) @(negedge clk);
    checks++; if (rdy_a - base !== 1) begin failures++; $display("FAIL g_rdy_count: got %0d want 1", rdy_a - base); end
    checks++; if (rx_data_a !== 8'h47) begin failures++; $display("FAIL g_rx_data: got %h want 47", rx_data_a); end
    // PWR1 ignores rider_off outside an 'S' byte.
    rider_off_a = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (pwr_up_a !== 1'b1) begin failures++; $display("FAIL g_pwr1_hold: got %b want 1", pwr_up_a); end
    rider_off_a = 1'b0;
    #1;
  endtask

  task automatic test_pwr2_rider_off();
    int base;
    base = rdy_a;
    send(1'b0, DIV_A, 8'h53, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (rdy_a - base !== 1) begin failures++; $display("FAIL s_rdy_count: got %0d want 1", rdy_a - base); end
    checks++; if (rx_data_a !== 8'h53) begin failures++; $display("FAIL s_rx_data: got %h want 53", rx_data_a); end
    checks++; if (pwr_up_a !== 1'b1) begin failures++; $display("FAIL s_pwr2_up: got %b want 1", pwr_up_a); end
    @(posedge clk);
    #1 rider_off_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL s_rider_off_drop: got %b want 0", pwr_up_a); end
    rider_off_a = 1'b0;
    #1;
  endtask

  task automatic test_s_with_rider_off();
    int base;
    send(1'b0, DIV_A, 8'h47, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (pwr_up_a !== 1'b1) begin failures++; $display("FAIL so_pwr1_up: got %b want 1", pwr_up_a); end
    rider_off_a = 1'b1;
    send(1'b0, DIV_A, 8'h53, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL so_s_off: got %b want 0", pwr_up_a); end
    base = rdy_a;
    send(1'b0, DIV_A, 8'h41, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (rdy_a - base !== 1) begin failures++; $display("FAIL so_a_rdy: got %0d want 1", rdy_a - base); end
    checks++; if (rx_data_a !== 8'h41) begin failures++; $display("FAIL so_a_data: got %h want 41", rx_data_a); end
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL so_a_pwr: got %b want 0", pwr_up_a); end
    rider_off_a = 1'b0;
    #1;
  endtask

  // PWR2 -> 'G' regrants PWR1; then rider_off raised on the rx_rdy cycle of a 'G' in PWR2 must win.
  task automatic test_pwr2();
    int t;
    send(1'b0, DIV_A, 8'h47, 1'b1);
    send(1'b0, DIV_A, 8'h53, 1'b1);
    send(1'b0, DIV_A, 8'h47, 1'b1);
    repeat (3) @(negedge clk);
    rider_off_a = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pwr_up_a !== 1'b1) begin failures++; $display("FAIL p2_regrant_pwr1: got %b want 1", pwr_up_a); end
    rider_off_a = 1'b0;
    send(1'b0, DIV_A, 8'h53, 1'b1);
    fork
      send(1'b0, DIV_A, 8'h47, 1'b1);
      begin
        t = 0;
        while (rx_rdy_a !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        rider_off_a = 1'b1;
        checks++; if (t >= 400) begin failures++; $display("FAIL p2_race_timeout: got no rx_rdy want pulse"); end
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL p2_race_off: got %b want 0", pwr_up_a); end
    checks++; if (rx_data_a !== 8'h47) begin failures++; $display("FAIL p2_race_data: got %h want 47", rx_data_a); end
    rider_off_a = 1'b0;
    #1;
  endtask

  task automatic test_frame_err();
    int base_r;
    int base_e;
    do_reset();
    base_r = rdy_a;
    base_e = err_a;
    send(1'b0, DIV_A, 8'h47, 1'b0);
    repeat (4) @(negedge clk);
`ifdef CMD_AUTH_FRAME_CHECK_EN
    checks++; if (err_a - base_e !== 1) begin failures++; $display("FAIL fe_err_pulse: got %0d want 1", err_a - base_e); end
    checks++; if (rdy_a - base_r !== 0) begin failures++; $display("FAIL fe_no_rdy: got %0d want 0", rdy_a - base_r); end
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL fe_pwr: got %b want 0", pwr_up_a); end
    checks++; if (rx_data_a !== 8'h00) begin failures++; $display("FAIL fe_data_kept: got %h want 00", rx_data_a); end
`else
    checks++; if (err_a - base_e !== 0) begin failures++; $display("FAIL fe_err_tied: got %0d want 0", err_a - base_e); end
    checks++; if (rdy_a - base_r !== 1) begin failures++; $display("FAIL fe_rdy: got %0d want 1", rdy_a - base_r); end
    checks++; if (pwr_up_a !== 1'b1) begin failures++; $display("FAIL fe_pwr: got %b want 1", pwr_up_a); end
    checks++; if (rx_data_a !== 8'h47) begin failures++; $display("FAIL fe_data: got %h want 47", rx_data_a); end
`endif
    base_r = rdy_a;
    send(1'b0, DIV_A, 8'h41, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (rdy_a - base_r !== 1) begin failures++; $display("FAIL fe_recover_rdy: got %0d want 1", rdy_a - base_r); end
    checks++; if (rx_data_a !== 8'h41) begin failures++; $display("FAIL fe_recover_data: got %h want 41", rx_data_a); end
  endtask

  task automatic test_glitch();
    int base;
    base = rdy_a;
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    checks++; if (rdy_a - base !== 0) begin failures++; $display("FAIL gl_no_rdy: got %0d want 0", rdy_a - base); end
    send(1'b0, DIV_A, 8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (rdy_a - base !== 1) begin failures++; $display("FAIL gl_next_rdy: got %0d want 1", rdy_a - base); end
    checks++; if (rx_data_a !== 8'hA5) begin failures++; $display("FAIL gl_next_data: got %h want a5", rx_data_a); end
  endtask

  // Reset lands inside bit 3 (a 0) of 'G' and is released while RX is still low.
  task automatic test_midframe_reset();
    int base;
    send(1'b0, DIV_A, 8'h47, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (pwr_up_a !== 1'b1) begin failures++; $display("FAIL mr_pre_pwr: got %b want 1", pwr_up_a); end
    base = rdy_a;
    rx_a = 1'b0;
    repeat (DIV_A) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (3 * DIV_A) @(posedge clk);
    #1 rx_a = 1'b0;
    repeat (DIV_A / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL mr_pwr_reset: got %b want 0", pwr_up_a); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (12 * DIV_A) @(posedge clk);
    @(negedge clk);
    checks++; if (rdy_a - base !== 0) begin failures++; $display("FAIL mr_no_rdy: got %0d want 0", rdy_a - base); end
    checks++; if (rx_data_a !== 8'h00) begin failures++; $display("FAIL mr_data_clear: got %h want 00", rx_data_a); end
    send(1'b0, DIV_A, 8'h53, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (rdy_a - base !== 1) begin failures++; $display("FAIL mr_new_rdy: got %0d want 1", rdy_a - base); end
    checks++; if (rx_data_a !== 8'h53) begin failures++; $display("FAIL mr_new_data: got %h want 53", rx_data_a); end
    checks++; if (pwr_up_a !== 1'b0) begin failures++; $display("FAIL mr_off_ignores_s: got %b want 0", pwr_up_a); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = rdy_b;
    rider_off_b = 1'b0;
    send(1'b1, DIV_B, 8'h47, 1'b1);
    send(1'b1, DIV_B, 8'h53, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (rdy_b - base !== 2) begin failures++; $display("FAIL b2b_rdy_count: got %0d want 2", rdy_b - base); end
    checks++; if (rx_data_b !== 8'h53) begin failures++; $display("FAIL b2b_data: got %h want 53", rx_data_b); end
    checks++; if (pwr_up_b !== 1'b1) begin failures++; $display("FAIL b2b_pwr: got %b want 1", pwr_up_b); end
    // Only PWR2 drops on rider_off alone, which pins the final state.
    rider_off_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pwr_up_b !== 1'b0) begin failures++; $display("FAIL b2b_state_pwr2: got %b want 0", pwr_up_b); end
    rider_off_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_grant();
    test_pwr2_rider_off();
    test_s_with_rider_off();
    test_pwr2();
    test_frame_err();
    test_glitch();
    test_midframe_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
